// File: rtl/datapath_control_unit.sv
// Multi-cycle control unit for the register/ALU/RAM datapath.
// Fetches a 32-bit instruction at the word-indexed pc and decodes it.
// Each instruction becomes a datapath control word valid for one EXEC cycle,
// or two cycles for LOAD. ALU status is latched for later conditional branches.
module datapath_control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  status,
  output logic [63:0] pc,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [63:0] K,
  output logic        BS,
  output logic [4:0]  FS,
  output logic        regW,
  output logic        ramW,
  output logic        selEN,
  output logic        halted
);

  localparam logic [4:0] FS_ADD = 5'b01000;

  localparam logic [3:0] OP_RTYPE = 4'h1;
  localparam logic [3:0] OP_ITYPE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_B     = 4'h5;
  localparam logic [3:0] OP_CBZ   = 4'h6;
  localparam logic [3:0] OP_BCOND = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;

  logic [3:0]  op;
  logic [4:0]  rd, rn, rm;
  logic [63:0] simm;
  logic [3:0]  cond;
  logic        bcond_taken;
  logic        unused_carry;

  assign op   = ir_q[31:28];
  assign rd   = ir_q[27:23];
  assign rn   = ir_q[22:18];
  assign rm   = ir_q[17:13];
  assign simm = {{51{ir_q[12]}}, ir_q[12:0]};
  assign cond = ir_q[26:23];
  assign pc   = pc_q;

  // The carry flag is latched with the others, but no branch condition tests it.
  assign unused_carry = flags_q[2];

  // Evaluate the branch condition against the flags latched from the last R/I op.
  always_comb begin
    bcond_taken = 1'b0;
    case (cond)
      4'd0:    bcond_taken = flags_q[0];
      4'd1:    bcond_taken = ~flags_q[0];
      4'd2:    bcond_taken = flags_q[1] ^ flags_q[3];
      4'd3:    bcond_taken = ~(flags_q[1] ^ flags_q[3]);
      default: bcond_taken = 1'b0;
    endcase
  end

  // State, pc, instruction and flag registers; reset aborts any in-flight instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic, including the pc, IR and flag updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 64'd1;
        case (op)
          OP_RTYPE, OP_ITYPE: flags_d = status;
          OP_LOAD: begin
            state_d = S_MEM;
            pc_d    = pc_q;
          end
          OP_B:     pc_d = pc_q + simm;
          OP_CBZ:   if (status[0]) pc_d = pc_q + simm;
          OP_BCOND: if (bcond_taken) pc_d = pc_q + simm;
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 64'd1;
      end
      default: ;
    endcase
  end

  // Control word, decoded combinationally from the current state and IR.
  always_comb begin
    DA     = '0;
    SA     = '0;
    SB     = '0;
    K      = '0;
    BS     = 1'b0;
    FS     = '0;
    regW   = 1'b0;
    ramW   = 1'b0;
    selEN  = 1'b0;
    halted = (state_q == S_HALT);
    case (state_q)
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin
            DA    = rd;
            SA    = rn;
            SB    = rm;
            FS    = ir_q[4:0];
            selEN = 1'b1;
            regW  = 1'b1;
          end
          OP_ITYPE: begin
            DA    = rd;
            SA    = rn;
            FS    = ir_q[17:13];
            K     = simm;
            BS    = 1'b1;
            selEN = 1'b1;
            regW  = 1'b1;
          end
          OP_LOAD: begin
            DA = rd;
            SA = rn;
            FS = FS_ADD;
            K  = simm;
            BS = 1'b1;
          end
          OP_STORE: begin
            SA   = rn;
            SB   = rd;
            FS   = FS_ADD;
            K    = simm;
            BS   = 1'b1;
            ramW = 1'b1;
          end
          OP_CBZ: begin
            SA = rd;
            FS = FS_ADD;
            BS = 1'b1;
          end
          default: ;
        endcase
      end
      // The address is held from EXEC so that the registered RAM data can be written back.
      S_MEM: begin
        DA   = rd;
        SA   = rn;
        FS   = FS_ADD;
        K    = simm;
        BS   = 1'b1;
        regW = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_control_unit.md
# datapath_control_unit

Multi-cycle control unit that drives the register/ALU/RAM datapath. It fetches 32-bit instructions by word-indexed program counter and decodes each into a datapath control word. The control word is DA, SA, SB, K, BS, FS, regW, ramW and selEN. The unit tracks ALU status for conditional branches. It sits between instruction memory and the datapath, and consumes the datapath's status output.

## Interface
- FS_ADD, 5'b01000: ALU function code for A+B, used for address generation and CBZ pass-through.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- instr  in  32  instruction word at address pc (combinational instruction memory).
- status  in  4  ALU status {V,C,N,Z}; status[0]=Z.
- pc  out  64  word-indexed program counter.
- DA, SA, SB  out  5 each  destination and source register selects.
- K  out  64  constant; sign-extended imm13.
- BS  out  1  1 selects K as ALU B input.
- FS  out  5  ALU function select.
- regW, ramW  out  1 each  register-file and RAM write enables.
- selEN  out  1  1 selects ALU result as writeback, 0 selects RAM.
- halted  out  1  high in HALT state.

## Operation
- Instruction fields: op=[31:28], rd=[27:23], rn=[22:18], rm=[17:13], imm13=[12:0]. simm = sign-extend(imm13) to 64 bits.
- States: FETCH, EXEC, MEM, HALT. Internal registers: IR(32), flags(4), pc.
- FETCH: latch IR<=instr. All enables, selects, K, BS and FS are 0. Next state is EXEC.
- EXEC control words by op. Default is all zero.
  - 0x1 RTYPE: DA=rd, SA=rn, SB=rm, FS=IR[4:0], BS=0, selEN=1, regW=1. flags<=status. pc+1.
  - 0x2 ITYPE: DA=rd, SA=rn, FS=IR[17:13], K=simm, BS=1, selEN=1, regW=1. flags<=status. pc+1.
  - 0x3 LOAD: DA=rd, SA=rn, FS=FS_ADD, K=simm, BS=1, selEN=0, regW=0. Next state MEM.
  - 0x4 STORE: SA=rn, SB=rd, FS=FS_ADD, K=simm, BS=1, ramW=1. pc+1.
  - 0x5 B: pc<=pc+simm.
  - 0x6 CBZ: SA=rd, FS=FS_ADD, K=0, BS=1. If status[0], pc<=pc+simm; else pc+1.
  - 0x7 BCOND: cond=IR[26:23] against latched flags. 0 EQ=Z, 1 NE=!Z, 2 LT=N^V, 3 GE=!(N^V), others never taken. Taken gives pc+simm, else pc+1.
  - 0xF HALT: next state HALT; pc unchanged.
  - Any other op: NOP, pc+1.
- Next state after EXEC is FETCH, except LOAD (MEM) and HALT (HALT).
- MEM: same control word as LOAD's EXEC, but regW=1. pc+1, next state FETCH.
- HALT: all enables 0, halted=1. Only reset exits HALT.
- pc arithmetic is 64-bit modulo 2^64. Wrap at 0xFFFF...FFFF+1 gives 0. Negative simm branches backward.
- Only RTYPE and ITYPE update flags. BCOND uses flags from the most recent R/I instruction.

## Timing
- Reset asynchronous: state=FETCH, pc=0, IR=0, flags=0, halted=0. All control outputs read 0.
- Reset asserted mid-instruction aborts it. Writes scheduled for that edge do not occur.
- Control outputs are combinational from state and IR. They are stable for the whole EXEC/MEM cycle, and writes commit on the edge ending that cycle.
- Latency per instruction:
  - 2 cycles for all except LOAD and HALT.
  - LOAD: 3 cycles (RAM read is registered; data returns in MEM).
  - HALT: 2 cycles to enter HALT.
- pc updates on the edge ending EXEC (or MEM for LOAD). instr must be valid during FETCH.
- CBZ samples status combinationally within EXEC. status must settle within the cycle.

## Test plan
- Reset/halt. Assert reset mid-EXEC of an RTYPE. Required: regW never pulses; pc=0, all outputs 0. First FETCH follows deassertion. instr=0xF0000000 at pc 0 gives halted=1 after 2 cycles, and pc stays 0 indefinitely.
- ITYPE/RTYPE. ITYPE rd=1, rn=31, FS=FS_ADD, imm13=5. Required in EXEC: DA=1, SA=31, K=5, BS=1, selEN=1, regW=1; pc goes 0→1. Then RTYPE: BS=0, SB=rm, FS=IR[4:0].
- LOAD/STORE.
  - STORE rd=2, rn=3, imm13=0x1FFF: K=0xFFFF_FFFF_FFFF_FFFF, SB=2, ramW=1 for exactly one cycle.
  - LOAD: regW=0 in EXEC, regW=1 with selEN=0 in MEM. pc advances after 3 cycles.
- CBZ. status=4'b0001 with imm13=0x1FFE at pc=10: pc becomes 8. status=0: pc becomes 11.
- BCOND. Drive status N=1, V=0 during an RTYPE, then give a BCOND LT. Required: taken, even if status changes during the BCOND EXEC. The same sequence with GE is not taken. cond=4 is never taken.
- Wrap. With pc=0xFFFF_FFFF_FFFF_FFFF, a NOP makes pc become 0.
